// File: rtl/hilo_mdu.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Operands are reduced to magnitudes on issue; signs are reapplied in FIX.
module hilo_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;

  // Signed ops are the even opcodes of the mult/div group.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiplier sits in the low half and is consumed LSB-first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Partial remainder in the upper half, dividend/quotient bits in the lower half.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dvsr_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start && !cancel) begin
        case (op)
          3'b100: hi_d = a;
          3'b101: lo_d = a;
          3'b000, 3'b001, 3'b010, 3'b011: begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = op[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = (b == '0);
            dvsr_d   = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
          end
          default: ;
        endcase
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Zero divisor yields all-ones quotient regardless of sign.
          lo_d = dz_q ? '1 : (neg_q ? -quot : quot);
          hi_d = rneg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cancel && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvsr_q   <= dvsr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed table, hand sequences for cancel/reset/busy
// corner cases, and random mult/div checked against an arithmetic model.
module tb_hilo_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] a = '0, b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;

  hilo_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, r, q, m;
    longint unsigned ux, uy, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'b000: begin r = sx * sy; return r; end
      3'b001: begin ur = ux * uy; return ur; end
      3'b010: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        m = sx % sy;
        return {m[31:0], q[31:0]};
      end
      3'b011: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Entered #1 after an edge; returns with clocks counted from the start edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int ncl, output int nb);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ncl = 1;
    nb = 0;
    while (!done && ncl < 100) begin
      if (busy) nb++;
      @(posedge clk); #1;
      ncl++;
    end
    rh = hi;
    rl = lo;
  endtask

  vec_t        tbl [6];
  logic [31:0] rh, rl;
  logic [63:0] exp;
  int          ncl, nb, ndone;

  initial begin
    tbl[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[4] = '{3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    tbl[5] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};

    #12;
    chk("reset_state", {hi, lo, 30'b0, busy, done}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, ncl, nb);
      chk($sformatf("tbl%0d_hi", i), rh, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), rl, tbl[i].lo);
      chk($sformatf("tbl%0d_clocks", i), ncl, 34);
      chk($sformatf("tbl%0d_busy_cycles", i), nb, 33);
    end

    // MTHI then MTLO back to back: one-edge update, never busy.
    op = 3'b100; a = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {busy, done}, 2'b00);
    op = 3'b101; a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_busy", {busy, done}, 2'b00);

    // Cancel at clock 10 of a MULTU.
    op = 3'b001; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", busy, 1'b0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("cancel_no_done", ndone, 0);
    chk("cancel_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    // Cancel together with start in IDLE: nothing issued.
    op = 3'b100; a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_hi", hi, 32'h1234_5678);
    chk("cancel_start_busy", busy, 1'b0);

    // Reset mid-operation clears everything asynchronously.
    op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {hi, lo, 30'b0, busy, done}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'b001, 32'd6, 32'd7, rh, rl, ncl, nb);
    chk("post_reset_mul", {rh, rl}, 64'd42);

    // Start while busy and a no-op in IDLE are both ignored.
    op = 3'b001; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 op = 3'b001; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ncl = 0;
    while (!done && ncl < 100) begin
      @(posedge clk); #1;
      ncl++;
    end
    chk("busy_start_result", {hi, lo}, 64'd6);
    op = 3'b110; a = 32'h5555_5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("ignored_ops_quiet", ndone, 0);
    chk("ignored_ops_hilo", {hi, lo}, 64'd6);

    // Random mult/div against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 3));
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom();
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = $urandom();
      endcase
      exp = model(o, x, y);
      run_op(o, x, y, rh, rl, ncl, nb);
      chk($sformatf("rnd%0d op%0d a=%0h b=%0h", i, o, x, y), {rh, rl}, exp);
      chk($sformatf("rnd%0d_clocks", i), ncl, 34);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
